// File: rtl/dff_bank_sequencer.sv
// Button-driven sequencer for a bank of single-bit reset/set/load flip-flops.
// Define DEBOUNCE_EN to insert a DB_CYCLES stability filter after the synchronizers.
module dff_bank_sequencer #(
  parameter int WIDTH     = 4,
  parameter int SW        = $clog2(WIDTH),
  parameter int DB_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             btn0_i,
  input  logic             btn1_i,
  input  logic             btn2_i,
  input  logic             btn3_i,
  input  logic [SW-1:0]    sel_i,
  output logic [WIDTH-1:0] dff_rst_o,
  output logic [WIDTH-1:0] dff_set_o,
  output logic [WIDTH-1:0] dff_ld_o,
  output logic             busy_o,
  output logic [SW-1:0]    ptr_o
);

  // state  | meaning
  // S_IDLE | waiting for a set/load/scan request
  // S_SCAN | loading bit ptr_q, one bit per cycle
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1} state_t;

  localparam logic [SW-1:0] PTR_LAST = SW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("dff_bank_sequencer: WIDTH must be 2..16");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("dff_bank_sequencer: DB_CYCLES must be >= 1");
  end

  state_t           state_q;
  logic [WIDTH-1:0] rst_q, set_q, ld_q;
  logic             busy_q;
  logic [SW-1:0]    ptr_q;

  logic [2:0] btn_raw;
  logic [2:0] sync1_q, sync2_q, edge_q;
  logic [2:0] lvl_d, req_d;
  logic       sel_ok_d;

  assign btn_raw = {btn3_i, btn2_i, btn1_i};

  always_ff @(posedge clk_i) begin
    if (btn0_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      edge_q  <= lvl_d;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic [CW-1:0] db_cnt_q [3];
  logic [2:0]    db_lvl_q;

  // Level only follows sync2 after it has disagreed for DB_CYCLES edges in a row.
  always_ff @(posedge clk_i) begin
    if (btn0_i) begin
      db_lvl_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != db_lvl_q[i]) begin
          if (db_cnt_q[i] == CW'(DB_CYCLES - 1)) begin
            db_lvl_q[i] <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign lvl_d = db_lvl_q;
`else
  assign lvl_d = sync2_q;
`endif

  assign req_d    = lvl_d & ~edge_q;
  assign sel_ok_d = ({1'b0, sel_i} < (SW + 1)'(WIDTH));

  function automatic logic [WIDTH-1:0] onehot(input logic [SW-1:0] idx);
    onehot = {{(WIDTH - 1){1'b0}}, 1'b1} << idx;
  endfunction

  always_ff @(posedge clk_i) begin
    if (btn0_i) begin
      state_q <= S_IDLE;
      rst_q   <= '1;
      set_q   <= '0;
      ld_q    <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      rst_q <= '0;
      set_q <= '0;
      ld_q  <= '0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          ptr_q  <= '0;
          // Fixed priority set > load > scan; losers are dropped.
          if (req_d[0]) begin
            if (sel_ok_d) set_q <= onehot(sel_i);
          end else if (req_d[1]) begin
            if (sel_ok_d) ld_q <= onehot(sel_i);
          end else if (req_d[2]) begin
            state_q <= S_SCAN;
            ld_q    <= onehot('0);
            busy_q  <= 1'b1;
          end
        end
        S_SCAN: begin
          if (ptr_q == PTR_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + SW'(1);
            ld_q  <= onehot(ptr_q + SW'(1));
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  assign dff_rst_o = rst_q;
  assign dff_set_o = set_q;
  assign dff_ld_o  = ld_q;
  assign busy_o    = busy_q;
  assign ptr_o     = ptr_q;

endmodule

// File: tb/tb_dff_bank_sequencer.sv
// Scoreboard bench for dff_bank_sequencer (WIDTH=4); honours DEBOUNCE_EN when defined.
module tb_dff_bank_sequencer;

`ifdef DEBOUNCE_EN
  localparam int LAT = 19, PULSE = 18, HOLD = 20, GAP = 40;
`else
  localparam int LAT = 3, PULSE = 1, HOLD = 10, GAP = 8;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic [3:0] set;
    logic [3:0] ld;
    logic       busy;
    logic [1:0] ptr;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       btn0_i, btn1_i, btn2_i, btn3_i;
  logic [1:0] sel_i;
  logic [3:0] dff_rst_o, dff_set_o, dff_ld_o;
  logic       busy_o;
  logic [1:0] ptr_o;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;
  exp_t sb[$];

  dff_bank_sequencer #(.WIDTH(4), .DB_CYCLES(16)) dut (
    .clk_i(clk_i), .btn0_i(btn0_i), .btn1_i(btn1_i), .btn2_i(btn2_i),
    .btn3_i(btn3_i), .sel_i(sel_i), .dff_rst_o(dff_rst_o),
    .dff_set_o(dff_set_o), .dff_ld_o(dff_ld_o), .busy_o(busy_o), .ptr_o(ptr_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_at(input int c, input logic [3:0] rst, input logic [3:0] set,
                           input logic [3:0] ld, input logic busy, input logic [1:0] ptr);
    exp_t e;
    e.cyc = c; e.rst = rst; e.set = set; e.ld = ld; e.busy = busy; e.ptr = ptr;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Every cycle without a scheduled entry must show all outputs idle.
  always @(negedge clk_i) begin
    exp_t e;
    if (cyc >= 1 && !done) begin
      e.cyc = cyc; e.rst = '0; e.set = '0; e.ld = '0; e.busy = 1'b0; e.ptr = '0;
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("sb_stale", 32'(sb[0].cyc), 32'(cyc));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) e = sb.pop_front();
      chk("rst", 32'(dff_rst_o), 32'(e.rst));
      chk("set", 32'(dff_set_o), 32'(e.set));
      chk("ld", 32'(dff_ld_o), 32'(e.ld));
      chk("busy", 32'(busy_o), 32'(e.busy));
      chk("ptr", 32'(ptr_o), 32'(e.ptr));
    end
  end

  initial begin
    int e0;
    btn0_i = 1'b1; btn1_i = 1'b0; btn2_i = 1'b0; btn3_i = 1'b0; sel_i = 2'd0;
    for (int c = 1; c <= 3; c++) expect_at(c, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0);
    tick(3);
    btn0_i = 1'b0;
    tick(GAP);

    // held set press fires once
    e0 = cyc; sel_i = 2'd2;
    expect_at(e0 + LAT, 4'h0, 4'b0100, 4'h0, 1'b0, 2'd0);
    btn1_i = 1'b1; tick(HOLD); btn1_i = 1'b0;
    tick(GAP);

    // single-bit load on the top bit
    e0 = cyc; sel_i = 2'd3;
    expect_at(e0 + LAT, 4'h0, 4'h0, 4'b1000, 1'b0, 2'd0);
    btn2_i = 1'b1; tick(PULSE); btn2_i = 1'b0;
    tick(GAP);

    // full scan
    e0 = cyc;
    for (int i = 0; i < 4; i++) expect_at(e0 + LAT + i, 4'h0, 4'h0, 4'(1 << i), 1'b1, 2'(i));
    btn3_i = 1'b1; tick(PULSE); btn3_i = 1'b0;
    tick(GAP);

    // set beats load on the same edge
    e0 = cyc; sel_i = 2'd1;
    expect_at(e0 + LAT, 4'h0, 4'b0010, 4'h0, 1'b0, 2'd0);
    btn1_i = 1'b1; btn2_i = 1'b1; tick(PULSE); btn1_i = 1'b0; btn2_i = 1'b0;
    tick(GAP);

    // load pressed mid-scan is discarded, even while still held afterwards
    e0 = cyc; sel_i = 2'd2;
    for (int i = 0; i < 4; i++) expect_at(e0 + LAT + i, 4'h0, 4'h0, 4'(1 << i), 1'b1, 2'(i));
    btn3_i = 1'b1; tick(2); btn2_i = 1'b1; tick(HOLD); btn2_i = 1'b0; btn3_i = 1'b0;
    tick(GAP);

    // reset aborts a scan at ptr=2 and it does not resume
    e0 = cyc;
    for (int i = 0; i < 3; i++) expect_at(e0 + LAT + i, 4'h0, 4'h0, 4'(1 << i), 1'b1, 2'(i));
    expect_at(e0 + LAT + 3, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0);
    btn3_i = 1'b1; tick(PULSE); btn3_i = 1'b0;
    tick(e0 + LAT + 2 - cyc);
    btn0_i = 1'b1; tick(1); btn0_i = 1'b0;
    tick(GAP);

`ifdef DEBOUNCE_EN
    // short glitch is filtered out
    sel_i = 2'd3;
    btn2_i = 1'b1; tick(5); btn2_i = 1'b0;
    tick(GAP);

    // stable press lands 18 cycles after its first sample
    e0 = cyc; sel_i = 2'd3;
    expect_at(e0 + 19, 4'h0, 4'h0, 4'b1000, 1'b0, 2'd0);
    btn2_i = 1'b1; tick(20); btn2_i = 1'b0;
    tick(GAP);
`endif

    done = 1'b1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
